mem_bus_arbiter: RTL and testbench

Shares the single-port main-memory interface between the I-cache line-refill path and the D-cache refill/write-back path of the cached RISC-V core. Each granted transaction is a fixed-length line burst of LINE_WORDS words. The arbiter sequences the burst beats, routes read data back to the owner, and signals completion. It sits between the two cache controllers and the SoC memory model in the minimal SOPC.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_beat_ctr.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding,
// owner identifiers and the beat-index width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST_I = 2'd1,
    BURST_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Number of bits needed to index 'value' words (value is a power of two).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_beat_ctr.sv
// Beat counter and burst address generator. The counter wraps to zero
// after the last beat, so a fresh burst always starts from beat 0.
module mem_arb_beat_ctr
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  localparam int BEAT_W    = clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  output logic [BEAT_W-1:0] beat,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  logic [BEAT_W-1:0] beat_reg;

  // Beat index: cleared while idle, stepped on each accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_reg <= '0;
    end else if (clear) begin
      beat_reg <= '0;
    end else if (advance) begin
      beat_reg <= beat_reg + BEAT_W'(1);
    end
  end

  assign beat = beat_reg;
  // Word-aligned byte address; wraps naturally modulo 2^ADDR_W.
  assign addr = base + ADDR_W'({beat_reg, 2'b00});
  assign last = (beat_reg == LAST_BEAT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-port main memory between the I-cache refill path
// and the D-cache refill/write-back path, one line burst per grant.
// Optional build macro ARB_RR_EN: round-robin on simultaneous requests;
// when undefined, the D-cache has fixed priority over the I-cache.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  localparam int BEAT_W    = clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [BEAT_W-1:0] d_widx,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // Byte-offset bits inside one line are dropped from the request address.
  localparam int OFF_W = BEAT_W + 2;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  arb_state_t        state_reg, state_next;
  logic              owner_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] base_reg;
  logic              grant_owner;
  logic              load;
  logic              ctr_clear;
  logic              ctr_advance;
  logic [BEAT_W-1:0] ctr_beat;
  logic [ADDR_W-1:0] ctr_addr;
  logic              ctr_last;
  logic              in_burst;
  logic              beat_done;
  logic [DATA_W-1:0] i_rdata_reg, d_rdata_reg;
  logic              i_rvalid_reg, d_rvalid_reg;

`ifdef ARB_RR_EN
  logic last_grant_reg;

  // Round-robin choice: on a tie, grant the side not granted last.
  always_comb begin
    grant_owner = d_req ? OWN_D : OWN_I;
    if (i_req && d_req) begin
      grant_owner = (last_grant_reg == OWN_D) ? OWN_I : OWN_D;
    end
  end

  // Last-granted pointer, updated on every grant; starts at D so I wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_reg <= OWN_D;
    end else if (load) begin
      last_grant_reg <= grant_owner;
    end
  end
`else
  // Fixed priority: D-cache wins whenever it requests.
  always_comb begin
    grant_owner = d_req ? OWN_D : OWN_I;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and counter control; arbitration happens only in IDLE.
  always_comb begin
    state_next  = state_reg;
    load        = 1'b0;
    ctr_clear   = 1'b0;
    ctr_advance = 1'b0;
    case (state_reg)
      IDLE: begin
        ctr_clear = 1'b1;
        if (i_req || d_req) begin
          load       = 1'b1;
          state_next = (grant_owner == OWN_D) ? BURST_D : BURST_I;
        end
      end
      BURST_I, BURST_D: begin
        if (mem_ready) begin
          ctr_advance = 1'b1;
          if (ctr_last) state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction context captured at grant time and held for the whole burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_reg <= OWN_I;
      we_reg    <= 1'b0;
      base_reg  <= '0;
    end else if (load) begin
      owner_reg <= grant_owner;
      we_reg    <= (grant_owner == OWN_D) && d_we;
      base_reg  <= ((grant_owner == OWN_D) ? d_addr : i_addr) & ~LOW_MASK;
    end
  end

  mem_arb_beat_ctr #(
    .ADDR_W    (ADDR_W),
    .LINE_WORDS(LINE_WORDS)
  ) u_beat_ctr (
    .clk    (clk),
    .rst    (rst),
    .clear  (ctr_clear),
    .advance(ctr_advance),
    .base   (base_reg),
    .beat   (ctr_beat),
    .addr   (ctr_addr),
    .last   (ctr_last)
  );

  assign in_burst  = (state_reg == BURST_I) || (state_reg == BURST_D);
  assign beat_done = in_burst && mem_ready;

  // Read data return path: capture the beat and pulse the owner's rvalid next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata_reg  <= '0;
      d_rdata_reg  <= '0;
      i_rvalid_reg <= 1'b0;
      d_rvalid_reg <= 1'b0;
    end else begin
      i_rvalid_reg <= beat_done && (state_reg == BURST_I);
      d_rvalid_reg <= beat_done && (state_reg == BURST_D) && !we_reg;
      if (beat_done && (state_reg == BURST_I)) i_rdata_reg <= mem_rdata;
      if (beat_done && (state_reg == BURST_D) && !we_reg) d_rdata_reg <= mem_rdata;
    end
  end

  // Memory-side outputs are gated by the burst states so they read 0 otherwise.
  assign mem_ce    = in_burst;
  assign mem_we    = (state_reg == BURST_D) && we_reg;
  assign mem_addr  = in_burst ? ctr_addr : '0;
  assign mem_wdata = in_burst ? d_wdata : '0;
  assign d_widx    = in_burst ? ctr_beat : '0;

  assign i_rdata  = i_rdata_reg;
  assign i_rvalid = i_rvalid_reg;
  assign d_rdata  = d_rdata_reg;
  assign d_rvalid = d_rvalid_reg;
  assign i_done   = (state_reg == DONE) && (owner_reg == OWN_I);
  assign d_done   = (state_reg == DONE) && (owner_reg == OWN_D);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a table of line transactions
// (inputs plus expected grant order/base address) checked cycle by cycle,
// followed by a hand-written mid-burst reset sequence.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_rvalid;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_widx;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        d_done;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks;
  int errors;
  logic last_d;

  mem_bus_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .LINE_WORDS(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_rvalid (i_rvalid),
    .i_done   (i_done),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_widx   (d_widx),
    .d_rdata  (d_rdata),
    .d_rvalid (d_rvalid),
    .d_done   (d_done),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  // D-cache write data follows the requested beat index combinationally.
  assign d_wdata = 32'hD0 + {30'd0, d_widx};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        i_req;
    logic        d_req;
    logic        d_we;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    int          wait_beat;
    int          wait_n;
    logic        first_d;
    logic [31:0] i_base;
    logic [31:0] d_base;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_ce"}, {31'd0, mem_ce}, 32'd0);
    chk({tag, ".mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, ".mem_addr"}, mem_addr, 32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, ".i_rdata"}, i_rdata, 32'd0);
    chk({tag, ".i_rvalid"}, {31'd0, i_rvalid}, 32'd0);
    chk({tag, ".i_done"}, {31'd0, i_done}, 32'd0);
    chk({tag, ".d_rdata"}, d_rdata, 32'd0);
    chk({tag, ".d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
    chk({tag, ".d_done"}, {31'd0, d_done}, 32'd0);
    chk({tag, ".d_widx"}, {30'd0, d_widx}, 32'd0);
  endtask

  // Entered at the negedge of an IDLE cycle with requests already applied;
  // returns at the negedge of the IDLE cycle that follows DONE.
  task automatic do_burst(input logic own_d, input logic [31:0] base, input logic we,
                          input int wait_beat, input int wait_n);
    logic        prev_cmp;
    logic [31:0] prev_data;
    logic [31:0] data;
    int          w;
    #1;
    chk("idle.mem_ce", {31'd0, mem_ce}, 32'd0);
    chk("idle.done", {30'd0, i_done, d_done}, 32'd0);
    prev_cmp  = 1'b0;
    prev_data = 32'd0;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      w    = (b == wait_beat) ? wait_n : 0;
      data = (own_d ? 32'hC0 : 32'hA0) + b;
      for (int k = 0; k <= w; k++) begin
        mem_ready = (k == w);
        mem_rdata = data;
        #1;
        chk("beat.mem_ce", {31'd0, mem_ce}, 32'd1);
        chk("beat.mem_addr", mem_addr, base + 32'(b * 4));
        chk("beat.mem_we", {31'd0, mem_we}, {31'd0, we});
        chk("beat.d_widx", {30'd0, d_widx}, 32'(b));
        chk("beat.mem_wdata", mem_wdata, 32'hD0 + b);
        chk("beat.i_rvalid", {31'd0, i_rvalid}, {31'd0, prev_cmp && !own_d});
        chk("beat.d_rvalid", {31'd0, d_rvalid}, {31'd0, prev_cmp && own_d && !we});
        if (prev_cmp && !own_d) chk("beat.i_rdata", i_rdata, prev_data);
        if (prev_cmp && own_d && !we) chk("beat.d_rdata", d_rdata, prev_data);
        chk("beat.done", {30'd0, i_done, d_done}, 32'd0);
        prev_cmp  = (k == w);
        prev_data = data;
        @(negedge clk);
      end
    end
    // DONE cycle: requester drops its request here.
    mem_ready = 1'b0;
    if (own_d) d_req = 1'b0;
    else i_req = 1'b0;
    #1;
    chk("done.mem_ce", {31'd0, mem_ce}, 32'd0);
    chk("done.i_done", {31'd0, i_done}, {31'd0, !own_d});
    chk("done.d_done", {31'd0, d_done}, {31'd0, own_d});
    chk("done.i_rvalid", {31'd0, i_rvalid}, {31'd0, !own_d});
    chk("done.d_rvalid", {31'd0, d_rvalid}, {31'd0, own_d && !we});
    if (!own_d) chk("done.i_rdata", i_rdata, prev_data);
    if (own_d && !we) chk("done.d_rdata", d_rdata, prev_data);
    $display("txn owner=%s base=%h we=%0d wait_beat=%0d wait_n=%0d",
             own_d ? "D" : "I", base, we, wait_beat, wait_n);
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    logic first_d;
    checks    = 0;
    errors    = 0;
    last_d    = 1'b1;
    rst       = 1'b0;
    i_req     = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    i_addr    = 32'd0;
    d_addr    = 32'd0;
    mem_rdata = 32'd0;
    mem_ready = 1'b0;

    //            i_req d_req d_we i_addr         d_addr         wb  wn first_d i_base         d_base
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_0500, -1, 0, 1'b1, 32'h0000_0400, 32'h0000_0500};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_0500, -1, 0, 1'b1, 32'h0000_0400, 32'h0000_0500};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, -1, 0, 1'b0, 32'h0000_0100, 32'h0000_0000};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0340,  1, 2, 1'b1, 32'h0000_0000, 32'h0000_0340};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_010E, 32'h0000_0000, -1, 0, 1'b0, 32'h0000_0100, 32'h0000_0000};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_07F8,  3, 1, 1'b1, 32'h0000_0080, 32'h0000_07F0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFF4,  0, 1, 1'b1, 32'h0000_0000, 32'hFFFF_FFF0};

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      v       = vecs[r];
      i_addr  = v.i_addr;
      d_addr  = v.d_addr;
      d_we    = v.d_we;
      i_req   = v.i_req;
      d_req   = v.d_req;
      first_d = v.first_d;
`ifdef ARB_RR_EN
      if (v.i_req && v.d_req) first_d = !last_d;
`endif
      do_burst(first_d, first_d ? v.d_base : v.i_base, first_d && v.d_we, v.wait_beat, v.wait_n);
      last_d = first_d;
      if (v.i_req && v.d_req) begin
        do_burst(!first_d, !first_d ? v.d_base : v.i_base, !first_d && v.d_we, -1, 0);
        last_d = !first_d;
      end
      @(negedge clk);
    end

    // Reset asserted during beat 2 of a D read, then the burst restarts.
    d_addr    = 32'h0000_0200;
    d_we      = 1'b0;
    d_req     = 1'b1;
    i_req     = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'hC0;
    @(negedge clk);
    mem_rdata = 32'hC1;
    @(negedge clk);
    #1;
    chk("rst.pre_addr", mem_addr, 32'h0000_0208);
    chk("rst.pre_rvalid", {31'd0, d_rvalid}, 32'd1);
    rst       = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk_all_zero("rst.mid");
    @(negedge clk);
    chk_all_zero("rst.hold");
    rst    = 1'b1;
    last_d = 1'b1;
    $display("txn reset during beat 2, restarting D read at 00000200");
    do_burst(1'b1, 32'h0000_0200, 1'b0, -1, 0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
